// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - b_in one bit per clock, LSB first,
// through a single full-subtractor stage and a borrow flop.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             b_out_q, b_out_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             last_bit;
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;

    assign accept   = start && (state_q != RUN);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // One full-subtractor stage; the operands stay put and the counter selects the bit.
    always_comb begin
        a_bit   = a_q[cnt_q];
        b_bit   = b_q[cnt_q];
        d_bit   = a_bit ^ b_bit ^ br_q;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    end

    // Results are committed only on the last bit so they hold through the next RUN.
    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        br_d    = br_q;
        diff_d  = diff_q;
        b_out_d = b_out_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d   = a;
            b_d   = b;
            br_d  = b_in;
            cnt_d = '0;
        end else if (state_q == RUN) begin
            sh_d = {d_bit, sh_q[WIDTH-1:1]};
            br_d = br_next;
            if (last_bit) begin
                diff_d  = {d_bit, sh_q[WIDTH-1:1]};
                b_out_d = br_next;
                ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_bit != a_q[WIDTH-1]);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            b_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            b_out_q <= b_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign diff  = diff_q;
    assign b_out = b_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH = 4): stimulus pushes expected
// results with their due cycle, a negedge monitor pops and compares on done.
module tb_serial_subtractor;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             resetn;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bIn;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bOut;
   logic             ovf;

   typedef struct {
      logic [WIDTH-1:0] diff;
      logic             bOut;
      logic             ovf;
      int unsigned      cyc;
      string            name;
   } expT;

   expT         expQ[$];
   int          nChecks = 0;
   int          nFails  = 0;
   int unsigned cyc     = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .resetn(resetn),
      .start (start),
      .a     (a),
      .b     (b),
      .b_in  (bIn),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .b_out (bOut),
      .ovf   (ovf)
   );

   // Free-running clock and an edge counter used to time done pulses
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point; every check in the bench goes through here
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: each done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin : monitor
      expT e;
      if (done === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected done", 32'(done), 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput({e.name, " diff"},    32'(diff), 32'(e.diff));
            checkOutput({e.name, " b_out"},   32'(bOut), 32'(e.bOut));
            checkOutput({e.name, " ovf"},     32'(ovf),  32'(e.ovf));
            checkOutput({e.name, " latency"}, cyc,       e.cyc);
         end
      end
   end

   // Drives one start pulse; the edge that accepts it is E0, done is due after E0+WIDTH
   task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic bi, input logic [WIDTH-1:0] expDiff,
                                input logic expBOut, input logic expOvf,
                                input logic expectDone, input string name);
      @(negedge clk);
      start = 1'b1;
      a     = av;
      b     = bv;
      bIn   = bi;
      @(posedge clk);
      #1;
      if (expectDone) expQ.push_back('{expDiff, expBOut, expOvf, cyc + WIDTH, name});
   endtask

   // Covers the WIDTH RUN cycles; either scrambles the operands or holds a bogus start
   task automatic busyPhase(input logic holdStart);
      for (int i = 0; i < WIDTH; i++) begin
         @(negedge clk);
         if (holdStart) begin
            start = 1'b1;
            a     = 4'd0;
            b     = 4'd1;
            bIn   = 1'b0;
         end else begin
            start = 1'b0;
            a     = 4'($urandom);
            b     = 4'($urandom);
            bIn   = 1'($urandom);
         end
         checkOutput("busy in RUN", 32'(busy), 32'd1);
      end
   endtask

   task automatic doneCycle();
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy in DONE", 32'(busy), 32'd0);
   endtask

   task automatic runOp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi,
                        input logic [WIDTH-1:0] expDiff, input logic expBOut, input logic expOvf,
                        input string name);
      applyStimulus(av, bv, bi, expDiff, expBOut, expOvf, 1'b1, name);
      busyPhase(1'b0);
      doneCycle();
   endtask

   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      a      = '0;
      b      = '0;
      bIn    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset busy",  32'(busy), 32'd0);
      checkOutput("reset done",  32'(done), 32'd0);
      checkOutput("reset diff",  32'(diff), 32'd0);
      checkOutput("reset b_out", 32'(bOut), 32'd0);
      checkOutput("reset ovf",   32'(ovf),  32'd0);
      resetn = 1'b1;

      // -7 - 3 leaves the signed range, so ovf is set
      runOp(4'd9,  4'd3,  1'b0, 4'h6, 1'b0, 1'b1, "9-3");
      runOp(4'd3,  4'd9,  1'b0, 4'hA, 1'b1, 1'b1, "3-9");
      runOp(4'd7,  4'd8,  1'b0, 4'hF, 1'b1, 1'b1, "7-8");

      applyStimulus(4'd5, 4'd2, 1'b1, 4'h2, 1'b0, 1'b0, 1'b1, "5-2-1 held start");
      busyPhase(1'b1);
      doneCycle();

      runOp(4'd0,  4'd0,  1'b1, 4'hF, 1'b1, 1'b0, "0-0-1");
      runOp(4'd15, 4'd15, 1'b1, 4'hF, 1'b1, 1'b0, "15-15-1");
      runOp(4'd6,  4'd6,  1'b0, 4'h0, 1'b0, 1'b0, "6-6");

      // Abort in the second RUN cycle; no result may appear for it
      applyStimulus(4'd9, 4'd3, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, "aborted");
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy before abort", 32'(busy), 32'd1);
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      checkOutput("abort busy",  32'(busy), 32'd0);
      checkOutput("abort done",  32'(done), 32'd0);
      checkOutput("abort diff",  32'(diff), 32'd0);
      checkOutput("abort b_out", 32'(bOut), 32'd0);
      checkOutput("abort ovf",   32'(ovf),  32'd0);
      resetn = 1'b1;
      repeat (6) begin
         @(negedge clk);
         checkOutput("done after abort", 32'(done), 32'd0);
      end
      runOp(4'd8, 4'd1, 1'b0, 4'h7, 1'b0, 1'b1, "8-1 after reset");

      // Back-to-back: second start lands in the DONE cycle of the first
      applyStimulus(4'd12, 4'd5, 1'b0, 4'h7, 1'b0, 1'b1, 1'b1, "12-5 b2b");
      busyPhase(1'b0);
      applyStimulus(4'd2, 4'd7, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1, "2-7-1 b2b");
      busyPhase(1'b0);
      doneCycle();

      for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
      if (expQ.size() != 0) checkOutput("pending results", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule
